csr_file: RTL

Machine-side CSR unit for the Riscv151 core. It executes Zicsr instructions (CSRRW/S/C and immediate forms) issued by the execute stage. It holds the `tohost` register at 0x51E, which drives the core's top-level `csr` port; the ISA bench polls that port for pass/fail. It also holds the 64-bit `cycle` and `instret` counters read by test and benchmark programs.

---
 rtl/csr_file_if.sv | 26 ++
 rtl/csr_file.sv | 94 +++++++++
 2 files changed

// File: rtl/csr_file_if.sv
// EX-stage to CSR unit bus: Zicsr instruction fields in, old value / illegal / tohost out.
// Master is the execute stage; slave is the CSR file.
interface csr_file_if;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic        csr_imm;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic        src_zero;
    logic        stall;
    logic        retire;
    logic [31:0] rdata;
    logic        illegal;
    logic [31:0] csr;

    modport master (
        output csr_valid, csr_op, csr_imm, csr_addr, rs1_data, zimm, src_zero, stall, retire,
        input  rdata, illegal, csr
    );

    modport slave (
        input  csr_valid, csr_op, csr_imm, csr_addr, rs1_data, zimm, src_zero, stall, retire,
        output rdata, illegal, csr
    );
endinterface

// File: rtl/csr_file.sv
// Machine-side CSR unit: executes CSRRW/S/C(I), holds tohost and the 64-bit cycle/instret counters.
// Latency: rdata/illegal combinational from pre-update state; writes visible the next cycle.
// Backpressure: stall holds off the write until the first unstalled cycle; counters keep running.
module csr_file #(
    parameter logic [31:0] RESET_TOHOST = 32'h0
) (
    input  logic       clk,
    input  logic       rst,
    csr_file_if.slave  bus
);
    localparam logic [11:0] ADDR_TOHOST   = 12'h51E;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    logic [31:0] tohost_q, tohost_d;
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;

    logic        is_csr;
    logic        mapped;
    logic        read_only;
    logic        wr_req;
    logic        illegal;
    logic        we;
    logic [31:0] old_val;
    logic [31:0] src_val;
    logic [31:0] new_val;

    always_comb begin
        // funct3[1:0] == 00 is not a CSR instruction at all
        is_csr    = bus.csr_valid & (bus.csr_op != 2'b00);
        mapped    = 1'b1;
        read_only = 1'b1;
        old_val   = 32'h0;
        unique case (bus.csr_addr)
            ADDR_TOHOST: begin
                old_val   = tohost_q;
                read_only = 1'b0;
            end
            ADDR_CYCLE:    old_val = cycle_q[31:0];
            ADDR_CYCLEH:   old_val = cycle_q[63:32];
            ADDR_INSTRET:  old_val = instret_q[31:0];
            ADDR_INSTRETH: old_val = instret_q[63:32];
            default: begin
                mapped    = 1'b0;
                read_only = 1'b0;
            end
        endcase

        src_val = bus.csr_imm ? {27'b0, bus.zimm} : bus.rs1_data;

        new_val = src_val;
        unique case (bus.csr_op)
            OP_RS:   new_val = old_val | src_val;
            OP_RC:   new_val = old_val & ~src_val;
            default: new_val = src_val;
        endcase

        // RS/RC with a zero source is a pure read, so it never trips read-only protection
        wr_req  = (bus.csr_op == OP_RW) | ~bus.src_zero;
        illegal = is_csr & (~mapped | (read_only & wr_req));
        we      = is_csr & ~bus.stall & wr_req & ~illegal;

        tohost_d = tohost_q;
        if (we && (bus.csr_addr == ADDR_TOHOST)) begin
            tohost_d = new_val;
        end

        cycle_d   = cycle_q + 64'd1;
        instret_d = instret_q + {63'b0, bus.retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_q  <= RESET_TOHOST;
            cycle_q   <= 64'h0;
            instret_q <= 64'h0;
        end else begin
            tohost_q  <= tohost_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign bus.rdata   = (is_csr && mapped) ? old_val : 32'h0;
    assign bus.illegal = illegal;
    assign bus.csr     = tohost_q;
endmodule
